// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller.
package hilo_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL1 = 3'd1,
        MUL2 = 3'd2,
        DIV  = 3'd3,
        FIX  = 3'd4
    } state_t;

    // md_op one-hot bit positions {divu,div,multu,mult}
    localparam int unsigned MD_MULT  = 0;
    localparam int unsigned MD_MULTU = 1;
    localparam int unsigned MD_DIV   = 2;
    localparam int unsigned MD_DIVU  = 3;

    // hilo_op one-hot bit positions {mtlo,mthi,mflo,mfhi}
    localparam int unsigned HL_MFHI = 0;
    localparam int unsigned HL_MFLO = 1;
    localparam int unsigned HL_MTHI = 2;
    localparam int unsigned HL_MTLO = 3;

    // Busy-cycle latencies seen by the pipeline
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = 33;

endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// 32-step radix-2 restoring divider core on unsigned magnitudes.
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic [4:0]  count
);

    logic [31:0] dvs;
    logic [32:0] shifted;
    logic        fits;

    assign shifted = {remainder, quotient[31]};
    assign fits    = (shifted >= {1'b0, dvs});

    // Load operands on start, then shift/subtract one quotient bit per step
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
            count     <= '0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
            count     <= '0;
        end else if (step) begin
            if (fits) begin
                remainder <= 32'(shifted - {1'b0, dvs});
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= shifted[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
            // 5-bit counter wraps 31->0 on the very step that moves the FSM to FIX
            count <= count + 5'd1;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register file with multi-cycle mult/div sequencing and mthi/mtlo writes.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  md_op,
    input  logic [3:0]  hilo_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_result
);

    localparam logic [4:0] DIV_LAST = 5'(DIV_LAT - 2);

    state_t      state, state_nxt;
    logic        accept;
    logic        is_mult, is_multu, is_div, is_divu, is_md;
    logic [31:0] op_a, op_b;
    logic        mul_signed;
    logic [63:0] ext_a, ext_b, product;
    logic        sign_q, sign_r, div_zero;
    logic [31:0] mag_a, mag_b;
    logic [31:0] quo, rem;
    logic [4:0]  div_count;
    logic        div_start, div_step;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid & req_ready & ~cancel;

    // Priority decode mult > multu > div > divu
    assign is_mult  = md_op[MD_MULT];
    assign is_multu = ~md_op[MD_MULT] & md_op[MD_MULTU];
    assign is_div   = ~md_op[MD_MULT] & ~md_op[MD_MULTU] & md_op[MD_DIV];
    assign is_divu  = ~md_op[MD_MULT] & ~md_op[MD_MULTU] & ~md_op[MD_DIV] & md_op[MD_DIVU];
    assign is_md    = (md_op != 4'b0000);

    assign mag_a = (is_div & src1[31]) ? (~src1 + 32'd1) : src1;
    assign mag_b = (is_div & src2[31]) ? (~src2 + 32'd1) : src2;

    // Sign/zero extension makes the low 64 bits of one multiplier serve both mult and multu
    assign ext_a = {{32{mul_signed & op_a[31]}}, op_a};
    assign ext_b = {{32{mul_signed & op_b[31]}}, op_b};

    assign div_start = accept & (is_div | is_divu);
    assign div_step  = (state == DIV) & ~cancel;

    assign mf_result = hilo_op[HL_MFHI] ? hi :
                       hilo_op[HL_MFLO] ? lo : '0;

    div_iter u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem),
        .count     (div_count)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; cancel pulls any busy state straight back to IDLE
    always_comb begin
        state_nxt = state;
        if (state != IDLE && cancel) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (is_mult | is_multu)    state_nxt = MUL1;
                    else if (is_div | is_divu) state_nxt = DIV;
                end
                MUL1:    state_nxt = MUL2;
                MUL2:    state_nxt = IDLE;
                DIV:     if (div_count == DIV_LAST) state_nxt = FIX;
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand capture, product register, HI/LO writes and registered done pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi         <= '0;
            lo         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            mul_signed <= 1'b0;
            product    <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            div_zero   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (!is_md) begin
                        if (hilo_op[HL_MTHI]) hi <= src1;
                        if (hilo_op[HL_MTLO]) lo <= src1;
                    end else if (is_mult | is_multu) begin
                        op_a       <= src1;
                        op_b       <= src2;
                        mul_signed <= is_mult;
                    end else begin
                        sign_q   <= is_div & (src1[31] ^ src2[31]);
                        sign_r   <= is_div & src1[31];
                        div_zero <= (src2 == 32'd0);
                    end
                end
                MUL1: if (!cancel) product <= ext_a * ext_b;
                MUL2: if (!cancel) begin
                    hi   <= product[63:32];
                    lo   <= product[31:0];
                    done <= 1'b1;
                end
                FIX: if (!cancel) begin
                    if (!div_zero) begin
                        lo <= sign_q ? (~quo + 32'd1) : quo;
                        hi <= sign_r ? (~rem + 32'd1) : rem;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: vector table plus corner-case sequences.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  md_op;
    logic [3:0]  hilo_op;
    logic [31:0] src1, src2;
    logic        cancel;
    logic        busy, done;
    logic [31:0] hi, lo, mf_result;

    typedef struct {
        logic [3:0]  md;
        logic [3:0]  hl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t        vecs[14];
    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi, m_lo;

    hilo_muldiv_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .md_op     (md_op),
        .hilo_op   (hilo_op),
        .src1      (src1),
        .src2      (src2),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .mf_result (mf_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One request; md ops are scored when done appears, mt/mf ops right after E0
    task automatic run_op(input vec_t v, input string nm);
        int   cyc;
        exp_t e;
        @(negedge clk);
        chk({nm, "_ready"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; md_op = v.md; hilo_op = v.hl; src1 = v.a; src2 = v.b;
        if (v.md != 4'b0000) sbq.push_back('{hi: v.hi, lo: v.lo});
        @(posedge clk); #1;
        req_valid = 1'b0; md_op = '0; hilo_op = '0;
        if (v.md == 4'b0000) begin
            chk({nm, "_hi"}, {32'd0, hi}, {32'd0, v.hi});
            chk({nm, "_lo"}, {32'd0, lo}, {32'd0, v.lo});
            chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
            chk({nm, "_done"}, {63'd0, done}, 64'd0);
        end else begin
            cyc = 0;
            while (busy && cyc < 200) begin
                cyc++;
                @(posedge clk); #1;
            end
            chk({nm, "_busycyc"}, 64'(cyc), 64'(v.busy));
            chk({nm, "_done"}, {63'd0, done}, 64'd1);
            chk({nm, "_ready_after"}, {63'd0, req_ready}, 64'd1);
            chk({nm, "_sbq"}, 64'(sbq.size()), 64'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({nm, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
                chk({nm, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
            end
            @(posedge clk); #1;
            chk({nm, "_done_once"}, {63'd0, done}, 64'd0);
        end
        m_hi = v.hi;
        m_lo = v.lo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        vec_t v;

        vecs[0]  = '{4'b0000, 4'b0100, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'h0000_0000, 0};
        vecs[1]  = '{4'b0000, 4'b1000, 32'h0000_5678, 32'h0,         32'h0000_1234, 32'h0000_5678, 0};
        vecs[2]  = '{4'b0100, 4'b0000, 32'h0000_0055, 32'h0,         32'h0000_1234, 32'h0000_5678, DIV_LAT};
        vecs[3]  = '{4'b0000, 4'b0001, 32'h0000_DEAD, 32'h0,         32'h0000_1234, 32'h0000_5678, 0};
        vecs[4]  = '{4'b0001, 4'b0000, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[5]  = '{4'b0010, 4'b0000, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT};
        vecs[6]  = '{4'b0100, 4'b0000, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[7]  = '{4'b1000, 4'b0000, 32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT};
        vecs[8]  = '{4'b0100, 4'b0000, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT};
        vecs[9]  = '{4'b0100, 4'b0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT};
        vecs[10] = '{4'b0101, 4'b0000, 32'd3,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT};
        vecs[11] = '{4'b1100, 4'b0000, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[12] = '{4'b0010, 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
        vecs[13] = '{4'b0001, 4'b0100, 32'd3,         32'd4,         32'd0,         32'd12,        MUL_LAT};

        resetn = 1'b0; req_valid = 1'b0; md_op = '0; hilo_op = '0;
        src1 = '0; src2 = '0; cancel = 1'b0;
        m_hi = '0; m_lo = '0;

        // Reset state before any clock edge
        #2;
        chk("rst_hi",    {32'd0, hi},   64'd0);
        chk("rst_lo",    {32'd0, lo},   64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_ready", {63'd0, req_ready}, 64'd1);

        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            run_op(v, $sformatf("v%0d", i));
        end

        // Cancel in cycle 10 of a divide: abandon with no write and no done
        @(negedge clk);
        req_valid = 1'b1; md_op = 4'b0100; src1 = 32'd100; src2 = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0; md_op = '0;
        repeat (9) @(posedge clk);
        #1;
        chk("cxl_busy_before", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cxl_ready", {63'd0, req_ready}, 64'd1);
        chk("cxl_busy",  {63'd0, busy},      64'd0);
        chk("cxl_hi",    {32'd0, hi},        {32'd0, m_hi});
        chk("cxl_lo",    {32'd0, lo},        {32'd0, m_lo});
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        chk("cxl_no_done", 64'(dn), 64'd0);

        // Cancel beats a simultaneous request
        @(negedge clk);
        req_valid = 1'b1; md_op = '0; hilo_op = 4'b0100; src1 = 32'h0000_0BAD; cancel = 1'b1;
        @(posedge clk); #1;
        chk("cxlreq_hi", {32'd0, hi}, {32'd0, m_hi});
        md_op = 4'b0100; hilo_op = '0; src2 = 32'd3;
        @(posedge clk); #1;
        chk("cxlreq_busy", {63'd0, busy}, 64'd0);
        req_valid = 1'b0; md_op = '0; cancel = 1'b0;

        // mthi held while a mult is busy is only taken once IDLE returns
        @(negedge clk);
        req_valid = 1'b1; md_op = 4'b0001; src1 = 32'd5; src2 = 32'd6;
        @(posedge clk); #1;
        md_op = '0; hilo_op = 4'b0100; src1 = 32'h0000_ABCD;
        chk("bmt_ready_e0", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("bmt_hi_e1", {32'd0, hi}, {32'd0, m_hi});
        @(posedge clk); #1;
        chk("bmt_hi_e2",   {32'd0, hi},   64'd0);
        chk("bmt_lo_e2",   {32'd0, lo},   64'd30);
        chk("bmt_done_e2", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; hilo_op = '0;
        chk("bmt_hi_e3",   {32'd0, hi},   64'h0000_ABCD);
        chk("bmt_done_e3", {63'd0, done}, 64'd0);
        m_hi = 32'h0000_ABCD; m_lo = 32'd30;

        // mf_result selects registered HI/LO by hilo_op
        @(negedge clk);
        hilo_op = 4'b0001; #1;
        chk("mf_hi", {32'd0, mf_result}, {32'd0, m_hi});
        hilo_op = 4'b0010; #1;
        chk("mf_lo", {32'd0, mf_result}, {32'd0, m_lo});
        hilo_op = 4'b0000; #1;
        chk("mf_none", {32'd0, mf_result}, 64'd0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        req_valid = 1'b1; md_op = 4'b0100; src1 = 32'd100; src2 = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0; md_op = '0;
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_hi",   {32'd0, hi},   64'd0);
        chk("arst_lo",   {32'd0, lo},   64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("arst_ready", {63'd0, req_ready}, 64'd1);
        m_hi = '0; m_lo = '0;
        v = '{4'b0001, 4'b0000, 32'd3, 32'd4, 32'd0, 32'd12, MUL_LAT};
        run_op(v, "post_rst_mult");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
